mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words in the memory array.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before each response; legal range 0..15.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req  input  1  access request from the multicycle core; held high until ready.
REQ-006 we  input  1  1 = store, 0 = load; sampled with req.
REQ-007 addr  input  32  byte address, little-endian; sampled with req.
REQ-008 wdata  input  32  store data, right-aligned in the low bits; sampled with req.
REQ-009 funct3  input  3  access size/sign (000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu).
REQ-010 rdata  output  32  load result; valid only in the ready cycle.
REQ-011 ready  output  1  one-cycle completion pulse.
REQ-012 err  output  1  asserted with ready when the access is rejected.

Function
REQ-013 FSM states SHALL be IDLE, WAIT and RESP.
REQ-014 IDLE with req=1 SHALL latch we/addr/wdata/funct3 and load the wait counter with WAIT_CYCLES.
REQ-015 IDLE with req=1 SHALL transition to WAIT if WAIT_CYCLES>0, else directly to RESP.
REQ-016 WAIT SHALL decrement the counter each cycle and enter RESP in the cycle after it reaches 0.
REQ-017 Latency: req sampled at edge N gives ready high during cycle N+WAIT_CYCLES+1.
REQ-018 RESP SHALL perform the access, drive ready=1 for exactly one cycle, then return to IDLE.
REQ-019 Inputs SHALL be ignored outside IDLE; a deasserted req during WAIT does not cancel the access.
REQ-020 req still high in the IDLE cycle after RESP SHALL start a new transaction (minimum one idle cycle between accesses).
REQ-021 Loads: lb/lh SHALL sign-extend and lbu/lhu zero-extend the byte/half selected by addr[1:0]/addr[1]; lw returns the full word.
REQ-022 Stores SHALL modify only the addressed byte lanes (sb 1 lane, sh 2 lanes, sw 4 lanes); other bytes are preserved.
REQ-023 err=1 SHALL be asserted when any of the following holds:
- halfword access with addr[0]=1;
- word access with addr[1:0]!=00;
- addr[31:2] >= DEPTH_WORDS;
- funct3 in {011, 110, 111};
- we=1 with funct3 100 or 101.
REQ-024 On err, memory SHALL be unmodified and rdata=0.
REQ-025 For stores, and in every non-ready cycle, rdata SHALL be 0.
REQ-026 ready and err SHALL be registered outputs.

Reset
REQ-027 Reset SHALL force state=IDLE, counter=0, ready=0, err=0, rdata=0 and clear all latched request fields.
REQ-028 Reset during WAIT or RESP SHALL abandon the access: no memory write, no ready pulse.
REQ-029 Memory array contents SHALL NOT be reset.

Structure
REQ-030 Shared package mem_pkg SHALL hold the funct3 size constants, the FSM state encoding and the data width constant (32).
REQ-031 Sub-module byte_lane_unit (combinational) SHALL perform load extraction/extension and store lane-merge; mem_responder holds the FSM, counter, latches and array.

Verification
REQ-032 Word store/load: sw 0xDEADBEEF @0x10, then lw @0x10 -> rdata=0xDEADBEEF, err=0, ready exactly 3 cycles after req with WAIT_CYCLES=2.
REQ-033 Byte/half: after sw 0x80FF7F01 @0x20:
- lb @0x23 -> 0xFFFFFF80; lbu @0x23 -> 0x00000080;
- lh @0x22 -> 0xFFFF80FF; lhu @0x20 -> 0x00007F01.
REQ-034 Partial store: sb 0xAA @0x21 over 0x80FF7F01 -> lw @0x20 returns 0x80FFAA01.
REQ-035 Errors: each of the following -> err=1 with ready, rdata=0, and memory unchanged on a follow-up lw:
- lw @0x22;
- sh @0x23;
- lw @(DEPTH_WORDS*4);
- funct3=011.
REQ-036 Reset mid-WAIT: assert reset one cycle after a sw req -> no ready pulse; a subsequent lw of that address returns the pre-store value.
REQ-037 Timing: WAIT_CYCLES=0 -> ready in the cycle after the req edge; with req held high, the next ready follows exactly one IDLE cycle later.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants, FSM encoding and access-legality helpers for mem_responder
package mem_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Unsigned sizes only exist for loads.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// rtl/byte_lane_unit.sv - load extraction/extension and store byte-lane merge
module byte_lane_unit
    import mem_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] mem_word,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] store_word
);

    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [3:0]        lane_en;
    logic [DATA_W-1:0] wdata_sh;

    always_comb begin
        sel_byte = mem_word[{addr_lo, 3'b000} +: 8];
        sel_half = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'b0, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'b0, sel_half};
            default: load_data = mem_word;
        endcase

        // Right-aligned store data is moved up to the addressed lanes.
        case (funct3[1:0])
            2'b00: begin
                lane_en  = 4'b0001 << addr_lo;
                wdata_sh = wdata << {addr_lo, 3'b000};
            end
            2'b01: begin
                lane_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_sh = addr_lo[1] ? {wdata[15:0], 16'b0} : wdata;
            end
            default: begin
                lane_en  = 4'b1111;
                wdata_sh = wdata;
            end
        endcase

        store_word = mem_word;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) store_word[8*i +: 8] = wdata_sh[8*i +: 8];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder for a multicycle core
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err
);

    localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        cnt;
    logic              lat_we;
    logic [31:0]       lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [2:0]        lat_funct3;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic              in_range;
    logic              acc_err;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] mem_word;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;

    assign in_range = {2'b00, lat_addr[31:2]} < 32'(DEPTH_WORDS);
    assign idx      = lat_addr[IDX_W+1:2];
    assign mem_word = in_range ? mem[idx] : '0;
    assign acc_err  = !in_range || !f3_legal(lat_we, lat_funct3)
                   || misaligned(lat_funct3, lat_addr[1:0]);

    byte_lane_unit u_lanes (
        .funct3     (lat_funct3),
        .addr_lo    (lat_addr[1:0]),
        .mem_word   (mem_word),
        .wdata      (lat_wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            ready      <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_funct3 <= '0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        lat_we     <= we;
                        lat_addr   <= addr;
                        lat_wdata  <= wdata;
                        lat_funct3 <= funct3;
                        cnt        <= WAIT_INIT;
                        state      <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                // RESP is entered on the same edge the counter lands on zero.
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= ST_RESP;
                end
                ST_RESP: begin
                    ready <= 1'b1;
                    err   <= acc_err;
                    rdata <= (acc_err || lat_we) ? '0 : load_data;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // No reset: contents survive reset, and an async reset leaves RESP before this edge.
    always_ff @(posedge clk) begin
        if (state == ST_RESP && lat_we && !acc_err) mem[idx] <= store_word;
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder
module tb_mem_responder;

    localparam int DEPTH = 256;
    localparam int WAITS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [31:0] addr, wdata, rdata;
    logic [2:0]  funct3;
    logic        ready, err;

    logic        req0, we0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [2:0]  funct3_0;
    logic        ready0, err0;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_bytes [DEPTH*4];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .funct3(funct3), .rdata(rdata), .ready(ready), .err(err)
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .funct3(funct3_0), .rdata(rdata0), .ready(ready0), .err(err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Byte-addressed reference: legality rules, then byte copy with optional sign fill.
    task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f, output logic exp_err, output logic [31:0] exp_rd);
        int n;
        logic [31:0] v;
        n = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        exp_err = (f == 3'd3) || (f == 3'd6) || (f == 3'd7) || (w && f[2])
               || (a % n != 0) || ((a / 4) >= DEPTH);
        exp_rd = 32'h0;
        if (!exp_err) begin
            if (w) begin
                for (int k = 0; k < n; k++) model_bytes[int'(a) + k] = d[8*k +: 8];
            end else begin
                v = 32'h0;
                for (int k = 0; k < n; k++) v = v | (32'(model_bytes[int'(a) + k]) << (8*k));
                if (!f[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                exp_rd = v;
            end
        end
    endtask

    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f, output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; funct3 = f;
        @(posedge clk); #1;
        lat = 0; rd = 32'h0; e = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = i; rd = rdata; e = err;
                break;
            end
        end
        req = 1'b0;
        @(posedge clk); #1;
        check("ready_one_cycle", 32'(ready), 32'h0);
        check("rdata_idle_zero", rdata, 32'h0);
    endtask

    task automatic run_exp(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] f, input logic [31:0] exp_rd, input logic exp_e);
        logic [31:0] rd, mrd;
        logic e, merr;
        int lat;
        xact(w, a, d, f, rd, e, lat);
        model_access(w, a, d, f, merr, mrd);
        check({tag, "_lat"}, 32'(lat), 32'(WAITS + 1));
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, 32'(e), 32'(exp_e));
    endtask

    task automatic run_model(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        logic [31:0] rd, mrd;
        logic e, merr;
        int lat;
        model_access(w, a, d, f, merr, mrd);
        xact(w, a, d, f, rd, e, lat);
        check("rnd_lat", 32'(lat), 32'(WAITS + 1));
        check("rnd_rdata", rd, mrd);
        check("rnd_err", 32'(e), 32'(merr));
    endtask

    initial begin
        logic [7:0] pattern;
        logic       seen;
        logic [31:0] ra;

        reset = 1'b1;
        req = 0; we = 0; addr = 0; wdata = 0; funct3 = 0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; funct3_0 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_ready0", 32'(ready0), 32'h0);
        reset = 1'b0;

        run_exp("sw_word", 1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0);
        run_exp("lw_word", 0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0);

        run_exp("sw_20", 1, 32'h20, 32'h80FF7F01, 3'b010, 32'h0, 0);
        run_exp("lb_23", 0, 32'h23, 32'h0, 3'b000, 32'hFFFFFF80, 0);
        run_exp("lbu_23", 0, 32'h23, 32'h0, 3'b100, 32'h00000080, 0);
        run_exp("lh_22", 0, 32'h22, 32'h0, 3'b001, 32'hFFFF80FF, 0);
        run_exp("lhu_20", 0, 32'h20, 32'h0, 3'b101, 32'h00007F01, 0);
        run_exp("sb_21", 1, 32'h21, 32'h000000AA, 3'b000, 32'h0, 0);
        run_exp("lw_20_sb", 0, 32'h20, 32'h0, 3'b010, 32'h80FFAA01, 0);

        run_exp("err_lw_mis", 0, 32'h22, 32'h0, 3'b010, 32'h0, 1);
        run_exp("err_sh_mis", 1, 32'h23, 32'h1234, 3'b001, 32'h0, 1);
        run_exp("err_lw_oor", 0, 32'(DEPTH*4), 32'h0, 3'b010, 32'h0, 1);
        run_exp("err_f3_011", 1, 32'h20, 32'h12345678, 3'b011, 32'h0, 1);
        run_exp("err_sbu", 1, 32'h20, 32'h55, 3'b100, 32'h0, 1);
        run_exp("lw_20_after_err", 0, 32'h20, 32'h0, 3'b010, 32'h80FFAA01, 0);

        // Reset one cycle into WAIT must abandon the store.
        run_exp("sw_30", 1, 32'h30, 32'h11111111, 3'b010, 32'h0, 0);
        @(negedge clk);
        req = 1; we = 1; addr = 32'h30; wdata = 32'h22222222; funct3 = 3'b010;
        @(posedge clk); #1;
        req = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; seen = seen | ready; end
        reset = 1'b0;
        repeat (5) begin @(posedge clk); #1; seen = seen | ready; end
        check("rst_wait_no_ready", 32'(seen), 32'h0);
        run_exp("lw_30_after_rst", 0, 32'h30, 32'h0, 3'b010, 32'h11111111, 0);

        // Zero wait states with req held: ready every other cycle.
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 32'h0001_0000; funct3_0 = 3'b010;
        @(posedge clk); #1;
        pattern = 8'h0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            pattern[i] = ready0;
            if (ready0) check("w0_err", 32'(err0), 32'h1);
        end
        req0 = 0;
        check("w0_ready_pattern", 32'(pattern), 32'h55);

        for (int i = 0; i < 16; i++) run_model(1, 32'(i*4), $urandom, 3'b010);
        for (int i = 0; i < 80; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'(DEPTH*4 + $urandom_range(0, 255))
                                             : 32'($urandom_range(0, 63));
            run_model(1'($urandom_range(0, 1)), ra, $urandom, 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
